// File: rtl/led_dimmer.sv
// ---------------------------------------------------------------------------
// led_dimmer
//   Bus-mapped PWM dimmer and optional blinker placed between the raw LED
//   register peripheral and the board LED pins.
//
//   Registers (8-bit, read/write):
//     BaseAddr     DUTY  PWM on-time in ticks (0 = off, 255 = always on)
//     BaseAddr+1   CTRL  bit0 EN, bit1 BLINK, bits7:4 RATE, bits3:2 read 0
//
//   Build option:
//     LED_DIMMER_BLINK_EN  defined   -> blink counter, phase, BLINK/RATE bits
//                          undefined -> no blink logic, CTRL reads {7'b0, EN}
//
//   Ports:
//     CLK       in   system clock, rising edge
//     RESET     in   synchronous, active-high reset
//     BUS_DATA  io   8-bit shared data bus, driven only while reading us
//     BUS_ADDR  in   8-bit bus address
//     BUS_WE    in   1 = processor write
//     LED_IN    in   16-bit raw LED pattern
//     LED_PWM   out  16-bit dimmed/blinked pattern, registered
// ---------------------------------------------------------------------------
module led_dimmer #(
    parameter logic [7:0]  BaseAddr = 8'hC2,
    parameter int unsigned PRESCALE = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    input  logic [15:0] LED_IN,
    output logic [15:0] LED_PWM
);

    localparam logic [7:0] CtrlAddr = BaseAddr + 8'd1;
    localparam logic [7:0] PreLast  = 8'(PRESCALE - 1);
    localparam logic [7:0] PwmLast  = 8'd254;

    // Register file and bus interface
    logic [7:0]  r_duty;
    logic        r_en;
    logic        r_rd_en;
    logic        r_rd_ctrl;

    // PWM engine
    logic [7:0]  r_pre;
    logic [7:0]  r_pwm;
    logic [7:0]  r_shadow;
    logic [15:0] r_led;

    logic        w_hit_duty;
    logic        w_hit_ctrl;
    logic        w_wr_duty;
    logic        w_wr_ctrl;
    logic        w_tick;
    logic        w_wrap;
    logic        w_pwm_on;
    logic        w_blink_pass;
    logic        w_led_on;
    logic [7:0]  w_ctrl_rd;
    logic [7:0]  w_rd_data;

    assign w_hit_duty = (BUS_ADDR == BaseAddr);
    assign w_hit_ctrl = (BUS_ADDR == CtrlAddr);
    assign w_wr_duty  = BUS_WE & w_hit_duty;
    assign w_wr_ctrl  = BUS_WE & w_hit_ctrl;

    assign w_tick   = (r_pre == PreLast);
    assign w_wrap   = w_tick & (r_pwm == PwmLast);
    // PWM counter tops out at 254, so a shadow of 255 is on for every tick.
    assign w_pwm_on = (r_pwm < r_shadow);
    assign w_led_on = r_en & w_pwm_on & w_blink_pass;

    // The drive enable is registered; the data follows the live register so
    // a read returns the current contents.
    assign w_rd_data = r_rd_ctrl ? w_ctrl_rd : r_duty;
    assign BUS_DATA  = r_rd_en ? w_rd_data : 8'hzz;
    assign LED_PWM   = r_led;

    // NOTE: every register below is updated with <= so all of them sample
    // the pre-edge values; this is what makes a DUTY write coinciding with a
    // PWM wrap load the old DUTY into the shadow.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_duty    <= 8'hFF;
            r_en      <= 1'b1;
            r_rd_en   <= 1'b0;
            r_rd_ctrl <= 1'b0;
            r_pre     <= 8'd0;
            r_pwm     <= 8'd0;
            r_shadow  <= 8'hFF;
            r_led     <= 16'h0000;
        end else begin
            if (w_wr_duty) r_duty <= BUS_DATA;
            if (w_wr_ctrl) r_en   <= BUS_DATA[0];

            // A write cycle is never a read cycle, so writes win.
            r_rd_en   <= ~BUS_WE & (w_hit_duty | w_hit_ctrl);
            r_rd_ctrl <= w_hit_ctrl;

            if (!r_en) begin
                // Disabled: park the counters so enabling starts a fresh period.
                r_pre    <= 8'd0;
                r_pwm    <= 8'd0;
                r_shadow <= r_duty;
            end else begin
                r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
                if (w_tick) r_pwm <= (r_pwm == PwmLast) ? 8'd0 : r_pwm + 8'd1;
                if (w_wrap) r_shadow <= r_duty;
            end

            r_led <= LED_IN & {16{w_led_on}};
        end
    end

`ifdef LED_DIMMER_BLINK_EN
    logic       r_blink;
    logic [3:0] r_rate;
    logic [6:0] r_blink_cnt;
    logic       r_phase;
    logic [6:0] w_blink_last;

    // (RATE+1)*8-1 == RATE*8+7
    assign w_blink_last = {r_rate, 3'b111};
    assign w_ctrl_rd    = {r_rate, 2'b00, r_blink, r_en};
    assign w_blink_pass = r_phase | ~r_blink;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_blink     <= 1'b0;
            r_rate      <= 4'd0;
            r_blink_cnt <= 7'd0;
            r_phase     <= 1'b1;
        end else begin
            if (w_wr_ctrl) begin
                r_blink <= BUS_DATA[1];
                r_rate  <= BUS_DATA[7:4];
            end

            if (!r_en || w_wr_ctrl) begin
                r_blink_cnt <= 7'd0;
                r_phase     <= 1'b1;
            end else if (w_wrap) begin
                if (r_blink_cnt == w_blink_last) begin
                    r_blink_cnt <= 7'd0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 7'd1;
                end
            end
        end
    end
`else
    assign w_ctrl_rd    = {7'b0000000, r_en};
    assign w_blink_pass = 1'b1;
`endif

endmodule

// File: tb/tb_led_dimmer.sv
// ---------------------------------------------------------------------------
// tb_led_dimmer
//   Directed self-checking bench for led_dimmer (BaseAddr 8'hC2, PRESCALE 4,
//   PWM period 1020 CLK). Expected values adapt to LED_DIMMER_BLINK_EN.
// ---------------------------------------------------------------------------
module tb_led_dimmer;

    localparam logic [7:0] Base = 8'hC2;
    localparam logic [7:0] Ctrl = 8'hC3;

`ifdef LED_DIMMER_BLINK_EN
    localparam logic [7:0] ExpCtrl5F   = 8'h53;
    localparam int         ExpOffPhase = 0;
`else
    localparam logic [7:0] ExpCtrl5F   = 8'h01;
    localparam int         ExpOffPhase = 8160;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  bus_addr;
    logic        bus_we;
    logic [15:0] led_in;
    logic [15:0] led_pwm;
    logic        tb_oe;
    logic [7:0]  tb_dout;
    wire  [7:0]  bus_data;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign bus_data = tb_oe ? tb_dout : 8'hzz;

    // Undriven bus reads as 8'hFF.
    for (genvar g = 0; g < 8; g++) begin : g_pullup
        pullup (bus_data[g]);
    end

    led_dimmer #(
        .BaseAddr (Base),
        .PRESCALE (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (bus_data),
        .BUS_ADDR (bus_addr),
        .BUS_WE   (bus_we),
        .LED_IN   (led_in),
        .LED_PWM  (led_pwm)
    );

    // Returns on the falling edge just after the capturing rising edge.
    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        @(negedge CLK);
        bus_addr = addr;
        bus_we   = 1'b1;
        tb_oe    = 1'b1;
        tb_dout  = data;
        @(negedge CLK);
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        @(negedge CLK);
        bus_addr = addr;
        bus_we   = 1'b0;
        @(negedge CLK);
        data     = bus_data;
        bus_addr = 8'h00;
    endtask

    // Disable, load DUTY, then write CTRL; returns one falling edge after
    // the enabling edge, i.e. aligned to the start of a PWM period.
    task automatic restart(input logic [7:0] duty, input logic [7:0] ctrl);
        bus_write(Ctrl, 8'h00);
        bus_write(Base, duty);
        bus_write(Ctrl, ctrl);
    endtask

    task automatic measure(input int n, input logic [15:0] pat, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge CLK);
            if (led_pwm === pat) hits++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] rd;
        RESET    = 1'b1;
        bus_addr = 8'h00;
        bus_we   = 1'b0;
        tb_oe    = 1'b0;
        tb_dout  = 8'h00;
        led_in   = 16'hA5A5;
        repeat (3) @(negedge CLK);
        checks++;
        if (led_pwm !== 16'h0000) begin
            errors++;
            $display("FAIL reset_led: got %h expected %h", led_pwm, 16'h0000);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (led_pwm !== 16'hA5A5) begin
            errors++;
            $display("FAIL passthru_a5a5: got %h expected %h", led_pwm, 16'hA5A5);
        end
        led_in = 16'h1234;
        #1;
        checks++;
        if (led_pwm !== 16'hA5A5) begin
            errors++;
            $display("FAIL passthru_latency: got %h expected %h", led_pwm, 16'hA5A5);
        end
        @(negedge CLK);
        checks++;
        if (led_pwm !== 16'h1234) begin
            errors++;
            $display("FAIL passthru_1234: got %h expected %h", led_pwm, 16'h1234);
        end
        bus_read(Base, rd);
        checks++;
        if (rd !== 8'hFF) begin
            errors++;
            $display("FAIL reset_duty: got %h expected %h", rd, 8'hFF);
        end
        bus_read(Ctrl, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected %h", rd, 8'h01);
        end
    endtask

    task automatic test_duty_128;
        int hi;
        int lo;
        led_in = 16'hFFFF;
        restart(8'd128, 8'h01);
        measure(1020, 16'hFFFF, hi);
        measure(1020, 16'h0000, lo);
        checks++;
        if (hi !== 512) begin
            errors++;
            $display("FAIL duty128_high: got %0d expected %0d", hi, 512);
        end
        checks++;
        if (lo !== 508) begin
            errors++;
            $display("FAIL duty128_low: got %0d expected %0d", lo, 508);
        end
    endtask

    task automatic test_duty_extremes;
        int n;
        led_in = 16'h5A3C;
        restart(8'd0, 8'h01);
        measure(3060, 16'h0000, n);
        checks++;
        if (n !== 3060) begin
            errors++;
            $display("FAIL duty0_off: got %0d expected %0d", n, 3060);
        end
        restart(8'd255, 8'h01);
        measure(3060, 16'h5A3C, n);
        checks++;
        if (n !== 3060) begin
            errors++;
            $display("FAIL duty255_on: got %0d expected %0d", n, 3060);
        end
    endtask

    task automatic test_mid_period_write;
        int n;
        led_in = 16'hFFFF;
        restart(8'd128, 8'h01);
        repeat (300) @(negedge CLK);
        bus_write(Base, 8'd10);
        // Rest of the current period still uses 128: high through cycle 512.
        measure(718, 16'hFFFF, n);
        checks++;
        if (n !== 210) begin
            errors++;
            $display("FAIL midwrite_old_period: got %0d expected %0d", n, 210);
        end
        measure(1020, 16'hFFFF, n);
        checks++;
        if (n !== 40) begin
            errors++;
            $display("FAIL midwrite_next_period: got %0d expected %0d", n, 40);
        end
    endtask

    task automatic test_blink;
        logic [7:0] rd;
        int n;
        led_in = 16'hC33C;
        restart(8'd255, 8'h5F);
        bus_read(Ctrl, rd);
        checks++;
        if (rd !== ExpCtrl5F) begin
            errors++;
            $display("FAIL ctrl_readback: got %h expected %h", rd, ExpCtrl5F);
        end
        restart(8'd255, 8'h03);
        measure(8160, 16'hC33C, n);
        checks++;
        if (n !== 8160) begin
            errors++;
            $display("FAIL blink_on_phase: got %0d expected %0d", n, 8160);
        end
        measure(8160, 16'hC33C, n);
        checks++;
        if (n !== ExpOffPhase) begin
            errors++;
            $display("FAIL blink_off_phase: got %0d expected %0d", n, ExpOffPhase);
        end
        measure(100, 16'hC33C, n);
        checks++;
        if (n !== 100) begin
            errors++;
            $display("FAIL blink_on_again: got %0d expected %0d", n, 100);
        end
    endtask

    task automatic test_bus_decode;
        bus_write(Base, 8'h3C);
        @(negedge CLK);
        bus_addr = 8'hC1;
        bus_we   = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus_data !== 8'hFF) begin
            errors++;
            $display("FAIL read_c1_hiz: got %h expected %h", bus_data, 8'hFF);
        end
        bus_addr = 8'hC4;
        @(negedge CLK);
        checks++;
        if (bus_data !== 8'hFF) begin
            errors++;
            $display("FAIL read_c4_hiz: got %h expected %h", bus_data, 8'hFF);
        end
        bus_addr = Base;
        #1;
        checks++;
        if (bus_data !== 8'hFF) begin
            errors++;
            $display("FAIL read_not_yet: got %h expected %h", bus_data, 8'hFF);
        end
        @(negedge CLK);
        checks++;
        if (bus_data !== 8'h3C) begin
            errors++;
            $display("FAIL read_duty: got %h expected %h", bus_data, 8'h3C);
        end
        bus_addr = 8'hC4;
        #1;
        checks++;
        if (bus_data !== 8'h3C) begin
            errors++;
            $display("FAIL read_hold_one_cycle: got %h expected %h", bus_data, 8'h3C);
        end
        @(negedge CLK);
        checks++;
        if (bus_data !== 8'hFF) begin
            errors++;
            $display("FAIL read_release: got %h expected %h", bus_data, 8'hFF);
        end
        bus_addr = 8'h00;
    endtask

    task automatic test_disable;
        int n;
        led_in = 16'hFFFF;
        restart(8'd128, 8'h01);
        repeat (300) @(negedge CLK);
        bus_write(Ctrl, 8'h00);
        measure(50, 16'h0000, n);
        checks++;
        if (n !== 50) begin
            errors++;
            $display("FAIL disable_off: got %0d expected %0d", n, 50);
        end
        // Counters were parked at 0, so a fresh full-length on-time follows.
        bus_write(Ctrl, 8'h01);
        measure(512, 16'hFFFF, n);
        checks++;
        if (n !== 512) begin
            errors++;
            $display("FAIL reenable_high: got %0d expected %0d", n, 512);
        end
        measure(8, 16'h0000, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL reenable_low: got %0d expected %0d", n, 8);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rd;
        int n;
        led_in = 16'h0FF0;
        restart(8'd10, 8'h03);
        repeat (200) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (led_pwm !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_led: got %h expected %h", led_pwm, 16'h0000);
        end
        RESET = 1'b0;
        measure(1100, 16'h0FF0, n);
        checks++;
        if (n !== 1100) begin
            errors++;
            $display("FAIL midreset_passthru: got %0d expected %0d", n, 1100);
        end
        bus_read(Base, rd);
        checks++;
        if (rd !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_duty: got %h expected %h", rd, 8'hFF);
        end
        bus_read(Ctrl, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++;
            $display("FAIL midreset_ctrl: got %h expected %h", rd, 8'h01);
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_duty_128();
        test_duty_extremes();
        test_mid_period_write();
        test_blink();
        test_bus_decode();
        test_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_dimmer.md
LED_DIMMER -- requirements
Module: led_dimmer

Interface
REQ-001 SHALL have parameter BaseAddr, default 8'hC2, bus address of DUTY register; CTRL at BaseAddr+1.
REQ-002 SHALL have parameter PRESCALE, default 4, CLK cycles per PWM tick (legal 1..255).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port BUS_DATA  inout  8  shared data bus; driven only during a read of an owned address, else high-Z.
REQ-006 SHALL have port BUS_ADDR  input  8  bus address.
REQ-007 SHALL have port BUS_WE  input  1  bus write enable; 1 = processor writes.
REQ-008 SHALL have port LED_IN  input  16  raw LED pattern from the upstream LED register peripheral.
REQ-009 SHALL have port LED_PWM  output  16  dimmed/blinked pattern to the board LED pins, registered.

Function
REQ-010 SHALL hold DUTY[7:0] at BaseAddr and CTRL[7:0] at BaseAddr+1: CTRL bit0 EN, bit1 BLINK, bits7:4 RATE, bits3:2 read 0.
REQ-011 SHALL write DUTY/CTRL with BUS_DATA on a CLK edge where BUS_WE=1 and BUS_ADDR matches; other addresses ignored.
REQ-012 SHALL, on a CLK edge where BUS_WE=0 and BUS_ADDR matches, drive the addressed register onto BUS_DATA from the next cycle; the drive enable is registered and drops one cycle after the address leaves range or BUS_WE rises.
REQ-013 SHALL run a prescaler counting 0..PRESCALE-1 and emit a one-cycle tick when the count equals PRESCALE-1, then wrap to 0.
REQ-014 SHALL run an 8-bit PWM counter that increments on each tick and wraps 254->0 (period = 255 ticks).
REQ-015 SHALL load a duty shadow register from DUTY at every PWM wrap; DUTY writes mid-period take effect only from the next period.
REQ-016 SHALL compute pwm_on = (PWM counter < duty shadow): DUTY=0 gives constant off, DUTY=255 gives constant on.
REQ-017 SHALL count PWM wraps in a blink counter; when it reaches (RATE+1)*8-1 the blink phase toggles and the counter clears.
REQ-018 SHALL clear the blink counter and set the blink phase to 1 on any write to CTRL.
REQ-019 SHALL register LED_PWM[i] = LED_IN[i] & EN & pwm_on & (phase | ~BLINK), one CLK latency from LED_IN/counter state.
REQ-020 SHALL, while EN=0, hold prescaler, PWM counter, and blink counter at 0, hold the blink phase at 1, load the duty shadow every cycle, and drive LED_PWM to 0.
REQ-021 SHALL give a write precedence over a read when both conditions hold on the same edge; a simultaneous DUTY write and PWM wrap loads the old DUTY into the shadow.

Reset
REQ-022 SHALL on RESET set DUTY=8'hFF, CTRL=8'h01, prescaler=0, PWM counter=0, duty shadow=8'hFF, blink counter=0, phase=1, bus drive enable=0, LED_PWM=16'h0000.
REQ-023 SHALL, after reset deassertion, pass LED_IN to LED_PWM unmodified (1-cycle latency) until software writes registers.
REQ-024 SHALL abort any PWM/blink period in progress when RESET asserts mid-operation; no state survives.

Configuration
REQ-025 SHALL provide macro LED_DIMMER_BLINK_EN: defined -> blink counter, phase, and CTRL bits BLINK/RATE implemented per REQ-017/018.
REQ-026 SHALL, without LED_DIMMER_BLINK_EN, remove all blink logic: CTRL bits7:1 read 0, writes to them are ignored, and phase is treated as constant 1.

Verification
REQ-027 SHALL cover: reset, LED_IN=16'hA5A5 -> LED_PWM=16'hA5A5 one cycle later; reading BaseAddr returns 8'hFF and BaseAddr+1 returns 8'h01.
REQ-028 SHALL cover: DUTY=8'd128, PRESCALE=4, LED_IN=16'hFFFF -> LED_PWM high for 512 and low for 508 CLK per 1020-CLK period.
REQ-029 SHALL cover: DUTY=0 -> LED_PWM=0 constantly; DUTY=255 -> LED_PWM=LED_IN constantly across at least 3 periods.
REQ-030 SHALL cover: a DUTY write of 8'd10 mid-period -> the current period keeps the old duty and the next period shows 40 CLK high.
REQ-031 SHALL cover: CTRL=8'h03 (RATE=0) -> LED_PWM gated off for 8 periods (8160 CLK) and on for 8 periods, alternating; rebuild without LED_DIMMER_BLINK_EN -> CTRL reads 8'h01 and no gating occurs.
REQ-032 SHALL cover: read of address 8'hC4 or 8'hC1 -> BUS_DATA stays high-Z; CTRL=8'h00 -> LED_PWM=0 and counters frozen at 0.
